// File: rtl/div_unit_pkg.sv
// Shared state codes, handshake levels and aluop codes for the divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a {rem, quo} pair.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Shift the pair left by one; the quotient MSB becomes the new remainder LSB.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs_i};
  // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
  assign diff    = shifted[WIDTH-1:0] - dvs_i;

  // Keep the trial difference when non-negative, otherwise restore.
  always_comb begin
    rem_o = ge ? diff : shifted[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider, STEPS quotient bits per cycle, signed or unsigned.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               dbz_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               neg1_q, neg1_d, neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d, dbz_q, dbz_d;

  logic [STEPS:0][WIDTH-1:0] rem_c, quo_c;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   mag1, mag2, quo_fix, rem_fix;

  // Operand magnitudes; negative only counts for signed operations.
  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1    = op1_neg ? -opdata1_i : opdata1_i;
  assign mag2    = op2_neg ? -opdata2_i : opdata2_i;

  // Quotient negates on sign mismatch; remainder follows the dividend.
  // Most-negative / -1 wraps naturally through the magnitude arithmetic.
  assign quo_fix = (neg1_q ^ neg2_q) ? -quo_q : quo_q;
  assign rem_fix = neg1_q ? -rem_q : rem_q;

  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  genvar g;
  generate
    for (g = 0; g < STEPS; g++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_c[g]),
        .quo_i (quo_c[g]),
        .dvs_i (dvs_q),
        .rem_o (rem_c[g+1]),
        .quo_o (quo_c[g+1])
      );
    end
  endgenerate

  // Next-state and datapath control for FREE/BYZERO/ON/END.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        dbz_d    = 1'b0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            neg1_d  = op1_neg;
            neg2_d  = op2_neg;
            rem_d   = '0;
            quo_d   = mag1;
            dvs_d   = mag2;
            cnt_d   = '0;
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          dbz_d    = 1'b1;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else if (cnt_q != CW'(WIDTH)) begin
          rem_d = rem_c[STEPS];
          quo_d = quo_c[STEPS];
          cnt_d = cnt_q + CW'(STEPS);
        end else begin
          result_d = {rem_fix, quo_fix};
          dbz_d    = 1'b0;
          state_d  = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
          dbz_d    = 1'b0;
        end else begin
          ready_d = DivResultReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign dbz_o    = dbz_q;

endmodule
